csa_chunk_sequencer: RTL and testbench



---
 rtl/csa_seq_pkg.sv | 23 ++
 rtl/csa_slice.sv | 26 ++
 rtl/csa_chunk_sequencer.sv | 178 +++++++++++++++++
 tb/tb_csa_chunk_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the chunked carry-select add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Chunk counter width; a single-chunk build still needs one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational CHUNK_W-bit carry-select adder slice shared by every chunk.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the sequencer decides when the result is captured.
module csa_slice #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               c_in,
    output logic [CHUNK_W-1:0] s,
    output logic               c_out,
    output logic               msb_c_in
);

    logic [CHUNK_W:0] sum_c0;
    logic [CHUNK_W:0] sum_c1;

    // Both carry hypotheses are formed up front; the late-arriving carry only drives the select.
    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, 1'b1};
    assign {c_out, s} = c_in ? sum_c1 : sum_c0;

    // Carry into the MSB is recovered from the MSB sum bit; used for signed overflow.
    assign msb_c_in = a[CHUNK_W-1] ^ b[CHUNK_W-1] ^ s[CHUNK_W-1];

endmodule

// File: rtl/csa_chunk_sequencer.sv
// Multi-precision add/sub: one shared CHUNK_W slice walked LSB chunk first, carry held in a register.
// Latency: NUM_CHUNKS cycles from accept edge to out_valid; one op per NUM_CHUNKS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional CSA_SEQ_OVF_EN adds ovf_out.
module csa_chunk_sequencer #(
    parameter  int CHUNK_W    = 8,
    parameter  int NUM_CHUNKS = 4,
    localparam int TOT_W      = CHUNK_W * NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOT_W-1:0] a_in,
    input  logic [TOT_W-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOT_W-1:0] sum_out,
    output logic             carry_out
`ifdef CSA_SEQ_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    import csa_seq_pkg::*;

    localparam int              CNT_W    = cnt_width(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [TOT_W-1:0] a_q;
    logic [TOT_W-1:0] b_q;
    logic [TOT_W-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             step;
    logic             last_chunk;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] s_chunk;
    logic             c_chunk;
    logic             msb_c;

    assign last_chunk = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; in_ready depends only on state so it never follows out_ready combinationally.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the operand chunks addressed by the counter.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_chunk = a_q[k*CHUNK_W +: CHUNK_W];
                b_chunk = b_q[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    csa_slice #(
        .CHUNK_W (CHUNK_W)
    ) u_slice (
        .a        (a_chunk),
        .b        (b_chunk),
        .c_in     (carry_q),
        .s        (s_chunk),
        .c_out    (c_chunk),
        .msb_c_in (msb_c)
    );

    // Operand capture; subtraction is A + ~B + 1, the +1 entering as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= a_in;
            b_q <= b_in ^ {TOT_W{sub_in == MODE_SUB}};
        end
    end

    // Inter-chunk carry and chunk counter; counter wrap after the last chunk is never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            carry_q <= sub_in;
            cnt_q   <= '0;
        end else if (step) begin
            carry_q <= c_chunk;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result chunks land one per RUN cycle; final carry is captured with the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (step) begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    sum_q[k*CHUNK_W +: CHUNK_W] <= s_chunk;
                end
            end
            if (last_chunk) begin
                cout_q <= c_chunk;
            end
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = cout_q;

`ifdef CSA_SEQ_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it on the top chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (step && last_chunk) begin
            ovf_q <= msb_c ^ c_chunk;
        end
    end

    assign ovf_out = ovf_q;
`else
    logic msb_c_unused;
    assign msb_c_unused = msb_c;
`endif

endmodule

// File: tb/tb_csa_chunk_sequencer.sv
// Self-checking bench for csa_chunk_sequencer (CHUNK_W=8, NUM_CHUNKS=4).
// Compares against an arithmetic reference of A+B / A-B with carry, borrow and signed overflow.
// Define CSA_SEQ_OVF_EN to also exercise ovf_out.
module tb_csa_chunk_sequencer;

    localparam int CW  = 8;
    localparam int NC  = 4;
    localparam int TW  = CW * NC;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a_in;
    logic [TW-1:0] b_in;
    logic          sub_in;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] sum_out;
    logic          carry_out;
`ifdef CSA_SEQ_OVF_EN
    logic          ovf_out;
`endif

    int checks;
    int errors;
    int cyc;

    csa_chunk_sequencer #(
        .CHUNK_W    (CW),
        .NUM_CHUNKS (NC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out)
`ifdef CSA_SEQ_OVF_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference: plain wide arithmetic. Subtract carry means "no borrow".
    task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output logic [31:0] s, output logic c, output logic o);
        logic [32:0] wide;
        if (!sub) begin
            wide = {1'b0, a} + {1'b0, b};
            s    = wide[31:0];
            c    = wide[32];
            o    = (a[31] == b[31]) && (s[31] != a[31]);
        end else begin
            s = a - b;
            c = (a >= b);
            o = (a[31] != b[31]) && (s[31] != a[31]);
        end
    endtask

    // Drives one operation, scrambles inputs while busy, returns what the DUT presented in DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int dly,
                         output logic [31:0] s, output logic c, output logic o,
                         output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        n   = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) tmo = 1'b1;
        a_in     = a;
        b_in     = b;
        sub_in   = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        sub_in   = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) tmo = 1'b1;
        s = sum_out;
        c = carry_out;
`ifdef CSA_SEQ_OVF_EN
        o = ovf_out;
`else
        o = 1'b0;
`endif
        repeat (dly) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sub_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum_out !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum_out); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry_out); end
`ifdef CSA_SEQ_OVF_EN
        checks++; if (ovf_out !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_out); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [0:6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000005, 32'h00000007,
                                  32'h7FFFFFFF, 32'h80000000, 32'h00010000};
        logic [31:0] tb [0:6] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h00000005,
                                  32'h00000001, 32'h00000001, 32'h00010000};
        logic        tsub [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ts [0:6] = '{32'h00000100, 32'h00000000, 32'hFFFFFFFE, 32'h00000002,
                                  32'h80000000, 32'h7FFFFFFF, 32'h00020000};
        logic        tc [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        tovf [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] s;
        logic        c;
        logic        o;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], tsub[i], 0, s, c, o, lat, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout: handshake not seen, want one within 50 cycles", i); end
            checks++; if (lat != NC) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NC); end
            checks++; if (s !== ts[i]) begin errors++; $display("FAIL dir%0d_sum: got %h want %h", i, s, ts[i]); end
            checks++; if (c !== tc[i]) begin errors++; $display("FAIL dir%0d_carry: got %b want %b", i, c, tc[i]); end
`ifdef CSA_SEQ_OVF_EN
            checks++; if (o !== tovf[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b want %b", i, o, tovf[i]); end
`endif
        end
    endtask

    task automatic test_in_ready_window();
        int  low;
        int  n;
        bit  seen;
        out_ready = 1'b1;
        a_in      = 32'h000000FF;
        b_in      = 32'h00000001;
        sub_in    = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        low  = 0;
        seen = 1'b0;
        n    = 0;
        while (!in_ready && n < 50) begin
            low++;
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        checks++; if (low != NC + 1) begin errors++; $display("FAIL busy_window: in_ready low %0d cycles want %0d", low, NC + 1); end
        checks++; if (!seen) begin errors++; $display("FAIL busy_window_valid: out_valid seen=%b want 1", seen); end
    endtask

    task automatic test_backpressure();
        int n;
        a_in     = 32'h12345678;
        b_in     = 32'h11111111;
        sub_in   = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != NC) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, NC); end
        a_in     = 32'h00000003;
        b_in     = 32'h00000004;
        sub_in   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
            checks++; if (sum_out !== 32'h23456789) begin errors++; $display("FAIL bp_hold_sum%0d: got %h want 23456789", i, sum_out); end
            checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL bp_hold_carry%0d: got %b want 0", i, carry_out); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_accept%0d: in_ready %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accepted: in_ready %b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (sum_out !== 32'h00000007) begin errors++; $display("FAIL bp_second_sum: got %h want 00000007", sum_out); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        logic        c;
        logic        o;
        int          lat;
        bit          tmo;
        int          n;
        a_in     = 32'h11111111;
        b_in     = 32'h22222222;
        sub_in   = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sum_out !== 32'h0) begin errors++; $display("FAIL midrst_sum: got %h want 0", sum_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL midrst_carry: got %b want 0", carry_out); end
`ifdef CSA_SEQ_OVF_EN
        checks++; if (ovf_out !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", ovf_out); end
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse%0d: got %b want 0", i, out_valid); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_after_ready: got %b want 1", in_ready); end
        do_op(32'h00010000, 32'h00010000, 1'b0, 1, s, c, o, lat, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL midrst_fresh_timeout: handshake not seen"); end
        checks++; if (s !== 32'h00020000) begin errors++; $display("FAIL midrst_fresh_sum: got %h want 00020000", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL midrst_fresh_carry: got %b want 0", c); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFFFFF;
                1: a = 32'h80000000 | ($urandom & 32'h000000FF);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h00000001;
                1: b = 32'h7FFFFFFF;
                default: b = $urandom;
            endcase
            sub = 1'($urandom_range(0, 1));
            ref_calc(a, b, sub, es, ec, eo);
            do_op(a, b, sub, int'($urandom_range(0, 3)), s, c, o, lat, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout: handshake not seen", i); end
            checks++; if (lat != NC) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, NC); end
            checks++; if (s !== es) begin errors++; $display("FAIL rnd%0d_sum: a=%h b=%h sub=%b got %h want %h", i, a, b, sub, s, es); end
            checks++; if (c !== ec) begin errors++; $display("FAIL rnd%0d_carry: a=%h b=%h sub=%b got %b want %b", i, a, b, sub, c, ec); end
`ifdef CSA_SEQ_OVF_EN
            checks++; if (o !== eo) begin errors++; $display("FAIL rnd%0d_ovf: a=%h b=%h sub=%b got %b want %b", i, a, b, sub, o, eo); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa;
        logic [31:0] pb;
        logic        psub;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        int          last_acc;
        int          n;
        bit          pend;
        out_ready = 1'b1;
        pend      = 1'b0;
        last_acc  = -1;
        es = '0; ec = 1'b0; eo = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pa   = $urandom;
            pb   = $urandom;
            psub = 1'($urandom_range(0, 1));
            a_in     = pa;
            b_in     = pb;
            sub_in   = psub;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                if (out_valid && pend) begin
                    checks++; if (sum_out !== es) begin errors++; $display("FAIL b2b%0d_sum: got %h want %h", i, sum_out, es); end
                    checks++; if (carry_out !== ec) begin errors++; $display("FAIL b2b%0d_carry: got %b want %b", i, carry_out, ec); end
`ifdef CSA_SEQ_OVF_EN
                    checks++; if (ovf_out !== eo) begin errors++; $display("FAIL b2b%0d_ovf: got %b want %b", i, ovf_out, eo); end
`endif
                    pend = 1'b0;
                end
                @(posedge clk); #1;
                n++;
            end
            checks++; if (n >= 50) begin errors++; $display("FAIL b2b%0d_timeout: in_ready not seen", i); end
            if (i > 0) begin
                checks++; if (pend) begin errors++; $display("FAIL b2b%0d_result_missing: pending=%b want 0", i, pend); end
            end
            ref_calc(pa, pb, psub, es, ec, eo);
            @(posedge clk); #1;
            if (last_acc >= 0) begin
                checks++; if (cyc - last_acc != NC + 2) begin errors++; $display("FAIL b2b%0d_interval: got %0d want %0d", i, cyc - last_acc, NC + 2); end
            end
            last_acc = cyc;
            pend     = 1'b1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (sum_out !== es) begin errors++; $display("FAIL b2b_last_sum: got %h want %h", sum_out, es); end
        checks++; if (carry_out !== ec) begin errors++; $display("FAIL b2b_last_carry: got %b want %b", carry_out, ec); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_in_ready_window();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
